viota_mask: RTL and testbench
=============================

// Module: viota_mask
// PURPOSE
//  Mask-to-index expander for viota.m, the counterpart of the vcpop.m mask popcount unit.
//  - Consumes 8-bit mask beats.
//  - Emits, for every mask element, the exclusive prefix count of set bits below it,
//    packed at the destination SEW.
//  - A running count carries across beats of one instruction.
//  - Sits in the vALU between the mask operand read port and the result writeback packer.
// PARAMETERS
//  REQ_DATA_WIDTH   8   mask bits per input beat (fixed at 8)
//  RESP_DATA_WIDTH  64  output beat width in bits
//  SEW_WIDTH        2   SEW encoding width: 0=8b, 1=16b, 2=32b, 3=64b
//  CNT_WIDTH        16  running-count width; wraps modulo 2^CNT_WIDTH
// PORTS
//  clk        in   1                one clock, rising edge
//  rst        in   1                asynchronous, active-low reset
//  in_m0      in   REQ_DATA_WIDTH   mask bits; bit i is element i of the beat
//  in_valid   in   1                input beat valid
//  in_first   in   1                first beat of an instruction; running count restarts at 0
//  in_last    in   1                last beat of an instruction
//  in_sew     in   SEW_WIDTH        destination SEW, sampled on accept
//  in_ready   out  1                block can accept an input beat
//  out_vec    out  RESP_DATA_WIDTH  packed prefix counts, element 0 in the LSBs
//  out_valid  out  1                out_vec holds a valid sub-beat
//  out_last   out  1                final sub-beat of the in_last beat
//  out_ready  in   1                downstream accepts out_vec
// BEHAVIOUR
//  - Reset (rst low, async):
//    - out_valid, out_last, out_vec, running count, sub-beat index, stored offsets all go to 0.
//    - FSM goes to IDLE. Any in-flight beat is dropped.
//  - Accept rule: a beat is accepted when in_valid && in_ready on a clk rising edge.
//  - Prefix computation on accept:
//    - base = in_first ? 0 : cnt.
//    - off[i] = popcount(in_m0[i-1:0]), 4 bits, i = 0..7.
//    - cnt <= base + popcount(in_m0), modulo 2^CNT_WIDTH.
//    - base, off[0..7] and the sew are registered.
//  - Sub-beat count per accepted beat, by SEW: 0 -> 1; 1 -> 2; 2 -> 4; 3 -> 8.
//  - E = 64 / 8<<sew elements per sub-beat.
//  - Sub-beat k, element j = (base + off[k*E + j]) truncated to the SEW width.
//  - Unused out_vec bits: none, since every SEW packs exactly 64 bits.
//  - Latency: out_valid rises on the cycle after accept.
//  - FSM states:
//    - IDLE: out_valid=0, in_ready=1.
//    - EMIT: out_valid=1.
//  - FSM transitions:
//    - IDLE --accept--> EMIT, k = 0.
//    - EMIT, out_ready && k < last: k++, out_vec advances next cycle.
//    - EMIT, out_ready && k == last, no accept: -> IDLE.
//  - in_ready = IDLE || (EMIT && k == last && out_ready). Combinational from state and out_ready.
//  - Simultaneous final-sub-beat handoff and new accept:
//    - Stays in EMIT with k = 0 and the new data.
//    - out_valid stays 1 (back-to-back, no bubble).
//  - Backpressure: while out_valid && !out_ready, out_vec, out_last and k are held stable.
//  - out_last = 1 only on the final sub-beat of a beat accepted with in_last.
//  - in_first && in_last on one beat: single-beat instruction, valid.
//  - A beat with in_first arriving mid-instruction restarts the count. No error is flagged.
//  - Wrap: running count and per-element values wrap silently. No saturation.
// STRUCTURE
//  - Shared vALU package holds:
//    - SEW encoding constants (SEW_8..SEW_64).
//    - Function elems_per_beat(sew).
//    - Function subbeats(sew).
//  - Sub-module vmask_prefix8: combinational 8-bit exclusive prefix popcount.
//    - Outputs off[0..7] and the total.
//    - Instantiated once.
//  - Top level holds the count register, the offset/base register, the FSM and the output mux.
// TESTING
//  1. SEW=0, in_first=1, in_m0=8'b1011_0110 -> out_vec=64'h0404030202010000 one cycle later.
//     Internal count becomes 5.
//  2. Follow-on beat (in_first=0), in_m0=8'hFF, SEW=0 -> out_vec=64'h0C0B0A0908070605.
//  3. SEW=1, in_first=1, in_m0=8'hFF, out_ready=1 ->
//     - 64'h0003000200010000, then 64'h0007000600050004.
//     - in_ready low during the first sub-beat.
//  4. SEW=0 beat with out_ready=0 for 3 cycles ->
//     - out_vec/out_valid stable, in_ready=0.
//     - Released on out_ready=1; a new beat accepted in the same cycle yields no bubble.
//  5. SEW=0: 32 beats of 8'hFF, then one more (in_last=1) ->
//     - 32nd beat bytes = F8..FF.
//     - 33rd beat bytes = 00..07 (wrap), with out_last=1.
//  6. SEW=3, 8'hFF accepted; rst low during sub-beat 3 ->
//     - out_valid=0 immediately (async), in_ready=1 after release.
//     - Next beat with in_first=0 starts from count 0.

Source files
------------

// File: rtl/viota_mask_pkg.sv
// viota_mask_pkg: shared vALU constants and helpers for the viota.m expander.
//   SEW_8..SEW_64     destination SEW encodings
//   elems_per_beat()  elements of that SEW packed into one 64-bit sub-beat
//   subbeats()        sub-beats needed to emit the 8 elements of one mask beat
package viota_mask_pkg;

    localparam int REQ_DATA_WIDTH  = 8;
    localparam int RESP_DATA_WIDTH = 64;
    localparam int SEW_WIDTH       = 2;
    localparam int CNT_WIDTH       = 16;
    localparam int OFF_WIDTH       = 4;

    localparam logic [SEW_WIDTH-1:0] SEW_8  = 2'd0;
    localparam logic [SEW_WIDTH-1:0] SEW_16 = 2'd1;
    localparam logic [SEW_WIDTH-1:0] SEW_32 = 2'd2;
    localparam logic [SEW_WIDTH-1:0] SEW_64 = 2'd3;

    typedef enum logic {
        ST_IDLE,
        ST_EMIT
    } state_e;

    function automatic logic [3:0] elems_per_beat(input logic [SEW_WIDTH-1:0] sew);
        case (sew)
            SEW_8:   return 4'd8;
            SEW_16:  return 4'd4;
            SEW_32:  return 4'd2;
            default: return 4'd1;
        endcase
    endfunction

    function automatic logic [3:0] subbeats(input logic [SEW_WIDTH-1:0] sew);
        case (sew)
            SEW_8:   return 4'd1;
            SEW_16:  return 4'd2;
            SEW_32:  return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/viota_mask_prefix8.sv
// vmask_prefix8: combinational exclusive prefix popcount of an 8-bit mask.
//   m_i      mask bits, bit i is element i
//   off_o    off_o[i] = number of set bits in m_i[i-1:0]
//   total_o  number of set bits in m_i
module vmask_prefix8
    import viota_mask_pkg::*;
(
    input  logic [REQ_DATA_WIDTH-1:0]                m_i,
    output logic [REQ_DATA_WIDTH-1:0][OFF_WIDTH-1:0] off_o,
    output logic [OFF_WIDTH-1:0]                     total_o
);

    logic [OFF_WIDTH-1:0] acc;

    always_comb begin
        acc = '0;
        for (int i = 0; i < REQ_DATA_WIDTH; i++) begin
            off_o[i] = acc;
            acc      = acc + {{(OFF_WIDTH-1){1'b0}}, m_i[i]};
        end
        total_o = acc;
    end

endmodule

// File: rtl/viota_mask.sv
// viota_mask: viota.m mask-to-index expander.
//   Accepts 8-bit mask beats and emits each element's exclusive prefix count of set
//   mask bits (carried across the beats of one instruction) packed at the destination
//   SEW, as 1/2/4/8 64-bit sub-beats per input beat.
//   clk, rst (async, active low)
//   in_m0/in_valid/in_first/in_last/in_sew -> in_ready   input beat handshake
//   out_vec/out_valid/out_last <- out_ready              output sub-beat handshake
module viota_mask
    import viota_mask_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REQ_DATA_WIDTH-1:0]  in_m0,
    input  logic                       in_valid,
    input  logic                       in_first,
    input  logic                       in_last,
    input  logic [SEW_WIDTH-1:0]       in_sew,
    output logic                       in_ready,
    output logic [RESP_DATA_WIDTH-1:0] out_vec,
    output logic                       out_valid,
    output logic                       out_last,
    input  logic                       out_ready
);

    state_e                                   state_q;
    logic [2:0]                               k_q;
    logic [CNT_WIDTH-1:0]                     cnt_q;
    logic [CNT_WIDTH-1:0]                     base_q;
    logic [REQ_DATA_WIDTH-1:0][OFF_WIDTH-1:0] off_q;
    logic [SEW_WIDTH-1:0]                     sew_q;
    logic                                     last_q;

    logic [REQ_DATA_WIDTH-1:0][OFF_WIDTH-1:0] off_d;
    logic [OFF_WIDTH-1:0]                     total_d;
    logic [CNT_WIDTH-1:0]                     base_d;
    logic [CNT_WIDTH-1:0]                     cnt_d;
    logic [3:0]                               nsub_m1;
    logic [2:0]                               last_k;
    logic                                     at_last;
    logic                                     accept;

    vmask_prefix8 u_prefix (
        .m_i     (in_m0),
        .off_o   (off_d),
        .total_o (total_d)
    );

    assign base_d  = in_first ? '0 : cnt_q;
    assign cnt_d   = base_d + {{(CNT_WIDTH-OFF_WIDTH){1'b0}}, total_d};
    assign nsub_m1 = subbeats(sew_q) - 4'd1;
    assign last_k  = nsub_m1[2:0];
    assign at_last = (k_q == last_k);

    // A new beat may enter while the final sub-beat is being handed off, so the
    // pipeline streams without a bubble.
    assign in_ready  = (state_q == ST_IDLE) || (at_last && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_EMIT);
    assign out_last  = out_valid && last_q && at_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            base_q  <= '0;
            off_q   <= '0;
            sew_q   <= SEW_8;
            last_q  <= 1'b0;
        end else if (accept) begin
            state_q <= ST_EMIT;
            k_q     <= '0;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            off_q   <= off_d;
            sew_q   <= in_sew;
            last_q  <= in_last;
        end else if (state_q == ST_EMIT && out_ready) begin
            if (at_last) state_q <= ST_IDLE;
            else         k_q     <= k_q + 3'd1;
        end
    end

    // Element index within the beat is k*E + j; with power-of-two E this is just
    // the sub-beat index concatenated with the lane index.
    logic [2:0]                 idx;
    logic [RESP_DATA_WIDTH-1:0] elem;

    always_comb begin
        out_vec = '0;
        idx     = '0;
        elem    = '0;
        case (sew_q)
            SEW_8: begin
                for (int j = 0; j < 8; j++) begin
                    idx  = 3'(j);
                    elem = {48'b0, base_q} + {60'b0, off_q[idx]};
                    out_vec[8*j +: 8] = elem[7:0];
                end
            end
            SEW_16: begin
                for (int j = 0; j < 4; j++) begin
                    idx  = {k_q[0], 2'(j)};
                    elem = {48'b0, base_q} + {60'b0, off_q[idx]};
                    out_vec[16*j +: 16] = elem[15:0];
                end
            end
            SEW_32: begin
                for (int j = 0; j < 2; j++) begin
                    idx  = {k_q[1:0], 1'(j)};
                    elem = {48'b0, base_q} + {60'b0, off_q[idx]};
                    out_vec[32*j +: 32] = elem[31:0];
                end
            end
            default: begin
                idx     = k_q;
                out_vec = {48'b0, base_q} + {60'b0, off_q[idx]};
            end
        endcase
    end

endmodule

// File: tb/tb_viota_mask.sv
module tb_viota_mask;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_m0 = '0;
    logic        in_valid = 1'b0;
    logic        in_first = 1'b0;
    logic        in_last = 1'b0;
    logic [1:0]  in_sew = '0;
    logic        in_ready;
    logic [63:0] out_vec;
    logic        out_valid;
    logic        out_last;
    logic        out_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] v;
        logic        l;
    } exp_t;

    exp_t expq[$];
    int   m_cnt = 0;

    viota_mask dut (
        .clk       (clk),
        .rst       (rst),
        .in_m0     (in_m0),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .in_last   (in_last),
        .in_sew    (in_sew),
        .in_ready  (in_ready),
        .out_vec   (out_vec),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Reference: element e of a beat gets base + (set bits below e), reduced to
    // the SEW width; elements are laid out in order, 64/SEW per output word.
    task automatic model_beat(input logic [7:0] m, input logic f, input logic l,
                              input logic [1:0] s);
        int base, w, e, nsub, idx, pc;
        longint unsigned val;
        logic [63:0] word;
        base = f ? 0 : m_cnt;
        w    = 8 << s;
        e    = 8 >> s;
        nsub = 1 << s;
        for (int k = 0; k < nsub; k++) begin
            word = '0;
            for (int j = 0; j < e; j++) begin
                idx = k * e + j;
                pc  = 0;
                for (int b = 0; b < idx; b++) pc += int'(m[b]);
                val = longint'(base + pc);
                if (w < 64) val = val % (64'd1 << w);
                word = word | (64'(val) << (j * w));
            end
            expq.push_back('{word, l && (k == nsub - 1)});
        end
        m_cnt = (base + $countones(m)) % 65536;
    endtask

    task automatic set_beat(input logic v, input logic [7:0] m, input logic f,
                            input logic l, input logic [1:0] s);
        in_valid = v; in_m0 = m; in_first = f; in_last = l; in_sew = s;
    endtask

    task automatic test_reset;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_vec !== 64'd0) begin errors++; $display("FAIL reset_out_vec got=%h exp=0", out_vec); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_prefix_sew8;
        @(negedge clk);
        set_beat(1'b1, 8'b1011_0110, 1'b1, 1'b0, 2'd0); out_ready = 1'b0;
        @(negedge clk);
        set_beat(1'b0, 8'h00, 1'b0, 1'b0, 2'd0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t1_valid got=%b exp=1", out_valid); end
        checks++; if (out_vec !== 64'h0404030202010000) begin errors++; $display("FAIL t1_vec got=%h exp=0404030202010000", out_vec); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL t1_in_ready got=%b exp=0", in_ready); end
        // Follow-on beat handed in while the first is consumed.
        set_beat(1'b1, 8'hFF, 1'b0, 1'b0, 2'd0); out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL t2_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        set_beat(1'b0, 8'h00, 1'b0, 1'b0, 2'd0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t2_valid got=%b exp=1", out_valid); end
        checks++; if (out_vec !== 64'h0C0B0A0908070605) begin errors++; $display("FAIL t2_vec got=%h exp=0C0B0A0908070605", out_vec); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t2_idle got=%b exp=0", out_valid); end
    endtask

    task automatic test_sew16;
        @(negedge clk);
        set_beat(1'b1, 8'hFF, 1'b1, 1'b0, 2'd1); out_ready = 1'b1;
        @(negedge clk);
        set_beat(1'b0, 8'h00, 1'b0, 1'b0, 2'd0);
        #1;
        checks++; if (out_vec !== 64'h0003000200010000) begin errors++; $display("FAIL t3_sub0 got=%h exp=0003000200010000", out_vec); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL t3_in_ready got=%b exp=0", in_ready); end
        @(negedge clk);
        checks++; if (out_vec !== 64'h0007000600050004) begin errors++; $display("FAIL t3_sub1 got=%h exp=0007000600050004", out_vec); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL t3_last got=%b exp=0", out_last); end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        set_beat(1'b1, 8'h0F, 1'b1, 1'b0, 2'd0); out_ready = 1'b0;
        @(negedge clk);
        set_beat(1'b0, 8'h00, 1'b0, 1'b0, 2'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_vec !== 64'h0404040403020100 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL t4_hold c=%0d valid=%b vec=%h rdy=%b exp 1/0404040403020100/0", c, out_valid, out_vec, in_ready);
            end
        end
        set_beat(1'b1, 8'h01, 1'b0, 1'b0, 2'd0); out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL t4_release_rdy got=%b exp=1", in_ready); end
        @(negedge clk);
        set_beat(1'b0, 8'h00, 1'b0, 1'b0, 2'd0);
        checks++; if (out_valid !== 1'b1 || out_vec !== 64'h0505050505050504) begin
            errors++; $display("FAIL t4_nobubble valid=%b vec=%h exp 1/0505050505050504", out_valid, out_vec);
        end
        @(negedge clk);
    endtask

    task automatic test_wrap;
        out_ready = 1'b1;
        for (int n = 1; n <= 34; n++) begin
            @(negedge clk);
            if (n == 33) begin
                checks++; if (out_vec !== 64'hFFFEFDFCFBFAF9F8) begin errors++; $display("FAIL t5_beat32 got=%h exp=FFFEFDFCFBFAF9F8", out_vec); end
            end
            if (n == 34) begin
                checks++; if (out_vec !== 64'h0706050403020100 || out_last !== 1'b1) begin
                    errors++; $display("FAIL t5_beat33 vec=%h last=%b exp 0706050403020100/1", out_vec, out_last);
                end
            end
            if (n <= 33) set_beat(1'b1, 8'hFF, n == 1, n == 33, 2'd0);
            else         set_beat(1'b0, 8'h00, 1'b0, 1'b0, 2'd0);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midflight;
        @(negedge clk);
        set_beat(1'b1, 8'hFF, 1'b1, 1'b0, 2'd3); out_ready = 1'b1;
        @(negedge clk);
        set_beat(1'b0, 8'h00, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++; if (out_vec !== 64'd3) begin errors++; $display("FAIL t6_sub3 got=%h exp=3", out_vec); end
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_vec !== 64'd0) begin
            errors++; $display("FAIL t6_async valid=%b vec=%h exp 0/0", out_valid, out_vec);
        end
        @(negedge clk); rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL t6_rdy got=%b exp=1", in_ready); end
        @(negedge clk);
        set_beat(1'b1, 8'hFF, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        set_beat(1'b0, 8'h00, 1'b0, 1'b0, 2'd0);
        checks++; if (out_vec !== 64'h0706050403020100) begin errors++; $display("FAIL t6_restart got=%h exp=0706050403020100", out_vec); end
        @(negedge clk);
    endtask

    task automatic test_random;
        exp_t e;
        logic first_done;
        expq.delete();
        first_done = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== (expq.size() != 0)) begin
                errors++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, out_valid, expq.size() != 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid && out_ready && expq.size() != 0) begin
                e = expq.pop_front();
                checks++;
                if (out_vec !== e.v || out_last !== e.l) begin
                    errors++; $display("FAIL rnd_data c=%0d vec=%h last=%b exp %h/%b", c, out_vec, out_last, e.v, e.l);
                end
            end
            set_beat($urandom_range(0, 2) != 0, 8'($urandom), !first_done || ($urandom_range(0, 7) == 0),
                     $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)));
            #1;
            if (in_valid && in_ready) begin
                model_beat(in_m0, in_first, in_last, in_sew);
                first_done = 1'b1;
            end
        end
        set_beat(1'b0, 8'h00, 1'b0, 1'b0, 2'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && expq.size() != 0; c++) begin
            @(negedge clk);
            e = expq.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_vec !== e.v || out_last !== e.l) begin
                errors++; $display("FAIL rnd_drain valid=%b vec=%h last=%b exp 1/%h/%b", out_valid, out_vec, out_last, e.v, e.l);
            end
        end
        @(negedge clk);
        checks++;
        if (expq.size() != 0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rnd_end pending=%0d valid=%b exp 0/0", expq.size(), out_valid);
        end
    endtask

    initial begin
        test_reset;
        test_prefix_sew8;
        test_sew16;
        test_backpressure;
        test_wrap;
        test_reset_midflight;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
